// File: rtl/ddr4_req_queue.sv
// In-order DDR4 request queue: timestamps accepted requests, decodes the
// address into row/bank/bank-group/column fields, releases the head after LAT cycles.
module ddr4_req_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 33,
    parameter int LAT    = 100,
    parameter int CNT_W  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_op,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [ADDR_W-19:0]         out_row,
    output logic [7:0]                 out_hcol,
    output logic [1:0]                 out_bank,
    output logic [1:0]                 out_bg,
    output logic [2:0]                 out_lcol,
    output logic [CNT_W-1:0]           out_arrival,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic                       empty,
    output logic                       err_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [1:0]        op_mem_r   [DEPTH];
    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [CNT_W-1:0]  arr_mem_r  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [OCC_W-1:0]  occ_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              err_r;

    logic              full_s;
    logic              empty_s;
    logic              ready_s;
    logic              accept_s;
    logic              push_s;
    logic              pop_s;
    logic              head_valid_s;
    logic [CNT_W-1:0]  age_s;
    logic [ADDR_W-1:0] head_addr_s;

    // Handshake qualification and head ageing; age is a modular difference so counter wrap is harmless.
    always_comb begin
        full_s       = (occ_r == OCC_W'(DEPTH));
        empty_s      = (occ_r == {OCC_W{1'b0}});
        ready_s      = rst_n & ~full_s;
        accept_s     = in_valid & ready_s;
        push_s       = accept_s & (in_op != 2'd3);
        age_s        = cnt_r - arr_mem_r[rd_ptr_r];
        head_valid_s = ~empty_s & (age_s >= CNT_W'(LAT));
        pop_s        = head_valid_s & out_ready;
        head_addr_s  = addr_mem_r[rd_ptr_r];
    end

    // Pointers, occupancy, free-running counter and illegal-op pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            occ_r    <= {OCC_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            err_r <= accept_s & (in_op == 2'd3);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
                2'b01:   occ_r <= occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head outputs never carry stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_mem_r[i]   <= 2'd0;
                addr_mem_r[i] <= {ADDR_W{1'b0}};
                arr_mem_r[i]  <= {CNT_W{1'b0}};
            end
        end else if (push_s) begin
            op_mem_r[wr_ptr_r]   <= in_op;
            addr_mem_r[wr_ptr_r] <= in_addr;
            arr_mem_r[wr_ptr_r]  <= cnt_r;
        end
    end

    // Head presentation and DDR4 field decode; addr[2:0] is the burst offset and is dropped.
    always_comb begin
        in_ready    = ready_s;
        out_valid   = head_valid_s;
        out_op      = op_mem_r[rd_ptr_r];
        out_addr    = head_addr_s;
        out_row     = head_addr_s[ADDR_W-1:18];
        out_hcol    = head_addr_s[17:10];
        out_bank    = head_addr_s[9:8];
        out_bg      = head_addr_s[7:6];
        out_lcol    = head_addr_s[5:3];
        out_arrival = arr_mem_r[rd_ptr_r];
        cycle_cnt   = cnt_r;
        occupancy   = occ_r;
        full        = full_s;
        empty       = empty_s;
        err_illegal = err_r;
    end

endmodule

// File: tb/tb_ddr4_req_queue.sv
// Bench for ddr4_req_queue: queue-based reference model under random and
// directed stimulus, a decode vector table, and an 8-bit-counter wrap instance.
module tb_ddr4_req_queue;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 33;
    localparam int LAT    = 100;
    localparam int CNT_W  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]        in_op = 2'd0;
    logic [ADDR_W-1:0] in_addr = '0;
    logic              in_ready, out_valid, full, empty, err_illegal;
    logic [1:0]        out_op, out_bank, out_bg;
    logic [ADDR_W-1:0] out_addr;
    logic [ADDR_W-19:0] out_row;
    logic [7:0]        out_hcol;
    logic [2:0]        out_lcol;
    logic [CNT_W-1:0]  out_arrival, cycle_cnt;
    logic [4:0]        occupancy;

    ddr4_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_addr(out_addr), .out_row(out_row), .out_hcol(out_hcol),
        .out_bank(out_bank), .out_bg(out_bg), .out_lcol(out_lcol),
        .out_arrival(out_arrival), .cycle_cnt(cycle_cnt), .occupancy(occupancy),
        .full(full), .empty(empty), .err_illegal(err_illegal));

    // Small-counter instance for the wrap case
    logic              rst8_n = 1'b0, in_valid8 = 1'b0;
    logic              in_ready8, out_valid8, full8, empty8, err8;
    logic [1:0]        out_op8, out_bank8, out_bg8;
    logic [ADDR_W-1:0] out_addr8;
    logic [ADDR_W-19:0] out_row8;
    logic [7:0]        out_hcol8, out_arrival8, cycle_cnt8;
    logic [2:0]        out_lcol8, occupancy8;

    ddr4_req_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .LAT(100), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_op(2'd1), .in_addr(33'h0_0000_0040), .out_valid(out_valid8), .out_ready(1'b0),
        .out_op(out_op8), .out_addr(out_addr8), .out_row(out_row8), .out_hcol(out_hcol8),
        .out_bank(out_bank8), .out_bg(out_bg8), .out_lcol(out_lcol8),
        .out_arrival(out_arrival8), .cycle_cnt(cycle_cnt8), .occupancy(occupancy8),
        .full(full8), .empty(empty8), .err_illegal(err8));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  arr;
    } ent_t;

    ent_t             mq[$];
    logic [CNT_W-1:0] mcnt = '0;
    logic             merr = 1'b0;

    logic             s_ov, s_acc, s_full, s_rdy;
    logic [CNT_W-1:0] s_cyc;

    // One clock of stimulus: drive, check against model at negedge, advance model at posedge
    task automatic step(input logic r, input logic v, input logic [1:0] op,
                        input logic [ADDR_W-1:0] a, input logic ordy);
        logic e_rdy, e_val, acc;
        logic [63:0] a64;
        rst_n = r; in_valid = v; in_op = op; in_addr = a; out_ready = ordy;
        if (!r) begin
            mq.delete();
            mcnt = '0;
            merr = 1'b0;
        end
        @(negedge clk);
        e_rdy = r && (mq.size() < DEPTH);
        e_val = 1'b0;
        if (r && mq.size() > 0) e_val = ((mcnt - mq[0].arr) >= 64'(LAT));
        chk("in_ready",    64'(in_ready),    64'(e_rdy));
        chk("out_valid",   64'(out_valid),   64'(e_val));
        chk("occupancy",   64'(occupancy),   64'(mq.size()));
        chk("full",        64'(full),        64'(mq.size() == DEPTH));
        chk("empty",       64'(empty),       64'(mq.size() == 0));
        chk("cycle_cnt",   cycle_cnt,        mcnt);
        chk("err_illegal", 64'(err_illegal), 64'(merr));
        if (mq.size() > 0) begin
            a64 = 64'(mq[0].addr);
            chk("out_op",      64'(out_op),   64'(mq[0].op));
            chk("out_addr",    64'(out_addr), a64);
            chk("out_arrival", out_arrival,   mq[0].arr);
            chk("out_row",     64'(out_row),  a64 / 64'd262144);
            chk("out_hcol",    64'(out_hcol), (a64 / 64'd1024) % 64'd256);
            chk("out_bank",    64'(out_bank), (a64 / 64'd256) % 64'd4);
            chk("out_bg",      64'(out_bg),   (a64 / 64'd64) % 64'd4);
            chk("out_lcol",    64'(out_lcol), (a64 / 64'd8) % 64'd8);
        end
        acc = v && e_rdy;
        s_ov = out_valid; s_acc = acc; s_cyc = mcnt; s_full = full; s_rdy = in_ready;
        @(posedge clk);
        if (r) begin
            if (e_val && ordy) void'(mq.pop_front());
            merr = acc && (op == 2'd3);
            if (acc && op != 2'd3) mq.push_back('{op, a, mcnt});
            mcnt = mcnt + 64'd1;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, '0, ordy);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        op;
        logic [14:0]       row;
        logic [7:0]        hcol;
        logic [1:0]        bank;
        logic [1:0]        bg;
        logic [2:0]        lcol;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int found;
        logic [CNT_W-1:0] first;
        logic [7:0] first8;

        tbl[0] = '{33'h0_0001_2345, 2'd0, 15'h0000, 8'h48, 2'd3, 2'd1, 3'd0};
        tbl[1] = '{33'h1_FFFF_FFFF, 2'd1, 15'h7FFF, 8'hFF, 2'd3, 2'd3, 3'd7};
        tbl[2] = '{33'h0_0004_0000, 2'd2, 15'h0001, 8'h00, 2'd0, 2'd0, 3'd0};
        tbl[3] = '{33'h0_0000_0038, 2'd0, 15'h0000, 8'h00, 2'd0, 2'd0, 3'd7};
        tbl[4] = '{33'h0_0000_00C0, 2'd1, 15'h0000, 8'h00, 2'd0, 2'd3, 3'd0};
        tbl[5] = '{33'h0_0000_0300, 2'd2, 15'h0000, 8'h00, 2'd3, 2'd0, 3'd0};
        tbl[6] = '{33'h0_0003_FC00, 2'd0, 15'h0000, 8'hFF, 2'd0, 2'd0, 3'd0};
        tbl[7] = '{33'h1_2345_6789, 2'd1, 15'h48D1, 8'h59, 2'd3, 2'd2, 3'd1};

        // Single request accepted at cycle 5 becomes visible at 105
        step(1'b0, 1'b0, 2'd0, '0, 1'b0);
        idle(5, 1'b0);
        step(1'b1, 1'b1, 2'd0, 33'h0_0001_2345, 1'b0);
        chk("t1_accept_cycle", s_cyc, 64'd5);
        first = '1;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b0, 2'd0, '0, 1'b0);
            if (s_ov) begin
                first = s_cyc;
                break;
            end
        end
        chk("t1_first_valid", first, 64'd105);
        chk("t1_row",  64'(out_row),     64'd0);
        chk("t1_hcol", 64'(out_hcol),    64'h48);
        chk("t1_bank", 64'(out_bank),    64'd3);
        chk("t1_bg",   64'(out_bg),      64'd1);
        chk("t1_lcol", 64'(out_lcol),    64'd0);
        chk("t1_arr",  out_arrival,      64'd5);
        step(1'b1, 1'b0, 2'd0, '0, 1'b1);

        // Decode vector table: push all, age them, pop in order
        step(1'b0, 1'b0, 2'd0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, tbl[i].op, tbl[i].addr, 1'b0);
        idle(100, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("tbl_valid", 64'(out_valid), 64'd1);
            chk("tbl_op",    64'(out_op),    64'(tbl[i].op));
            chk("tbl_row",   64'(out_row),   64'(tbl[i].row));
            chk("tbl_hcol",  64'(out_hcol),  64'(tbl[i].hcol));
            chk("tbl_bank",  64'(out_bank),  64'(tbl[i].bank));
            chk("tbl_bg",    64'(out_bg),    64'(tbl[i].bg));
            chk("tbl_lcol",  64'(out_lcol),  64'(tbl[i].lcol));
            chk("tbl_arr",   out_arrival,    64'(i));
            step(1'b1, 1'b0, 2'd0, '0, 1'b1);
        end
        chk("tbl_drained", 64'(empty), 64'd1);

        // 17 back-to-back requests: 17th waits for the first pop at 100
        step(1'b0, 1'b0, 2'd0, '0, 1'b0);
        found = 0;
        first = '1;
        for (int i = 0; i < 200 && found < 17; i++) begin
            step(1'b1, 1'b1, 2'd0, ADDR_W'(found * 64), 1'b1);
            if (s_cyc == 64'd16) begin
                chk("t2_full_at_16",  64'(s_full), 64'd1);
                chk("t2_ready_at_16", 64'(s_rdy),  64'd0);
            end
            if (s_acc) begin
                found++;
                if (found == 17) first = s_cyc;
            end
        end
        chk("t2_17th_accept", first, 64'd101);
        for (int i = 0; i < 400 && mq.size() > 0; i++) step(1'b1, 1'b0, 2'd0, '0, 1'b1);

        // Three aged entries held under backpressure, then three consecutive pops
        step(1'b0, 1'b0, 2'd0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'(i), ADDR_W'(33'h1_0000_0000 + i * 8), 1'b0);
        idle(100, 1'b0);
        idle(50, 1'b0);
        chk("t3_held_valid", 64'(out_valid), 64'd1);
        chk("t3_held_occ",   64'(occupancy), 64'd3);
        chk("t3_held_addr",  64'(out_addr),  64'h1_0000_0000);
        idle(3, 1'b1);
        chk("t3_drained", 64'(occupancy), 64'd0);

        // Illegal op: accepted, flagged for one cycle, never stored
        step(1'b1, 1'b1, 2'd3, 33'h0_0000_0100, 1'b1);
        chk("t4_ready", 64'(s_rdy), 64'd1);
        idle(150, 1'b1);

        // Reset in the middle of traffic discards stored entries
        step(1'b0, 1'b0, 2'd0, '0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 2'd1, ADDR_W'(i * 1024), 1'b0);
        idle(52, 1'b0);
        step(1'b0, 1'b0, 2'd0, '0, 1'b1);
        chk("t5_empty_in_rst",  64'(empty),     64'd1);
        chk("t5_cnt_in_rst",    cycle_cnt,      64'd0);
        chk("t5_ready_in_rst",  64'(in_ready),  64'd0);
        step(1'b0, 1'b0, 2'd0, '0, 1'b1);
        idle(201, 1'b1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = ADDR_W'({$urandom(), $urandom()});
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), ra, ($urandom_range(0, 2) != 0));
        end

        // Counter wrap on the 8-bit instance: accept at 200, valid at 44
        @(posedge clk); #1;
        rst8_n = 1'b1;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            if (cycle_cnt8 == 8'd200) begin
                chk("t6_ready", 64'(in_ready8), 64'd1);
                in_valid8 = 1'b1;
                found = 1;
                @(posedge clk); #1;
                in_valid8 = 1'b0;
            end
        end
        chk("t6_accepted", 64'(found), 64'd1);
        first8 = 8'hFF;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid8) begin
                first8 = cycle_cnt8;
                break;
            end
        end
        chk("t6_first_valid", 64'(first8),       64'd44);
        chk("t6_arrival",     64'(out_arrival8), 64'd200);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
